// File: rtl/max_reduce_arbiter.sv
// Round-robin arbiter sharing one byte-wise max-reduction datapath among N_REQ
// requesters; each granted burst yields one 8-bit max tagged with its owner.
module max_reduce_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  res_valid,
    output logic [7:0]            res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_trunc,
    input  logic                  res_ready,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   rr_ptr;
    logic [7:0]        acc;
    logic [CNT_W-1:0]  cnt;
    logic              trunc;

    logic [2*N_REQ-1:0] valid_dbl;
    logic [N_REQ-1:0]   valid_rot;
    logic [ID_W:0]      pick_off;
    logic [ID_W:0]      pick_sum;
    logic               pick_found;
    logic [ID_W-1:0]    pick;

    logic [N_REQ-1:0]   grant_oh;
    logic               grant_valid;
    logic               grant_last;
    logic [31:0]        word;
    logic [7:0]         word_max;
    logic               hs;
    logic               end_burst;

    function automatic logic [7:0] max4(input logic [31:0] w);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = (w[31:24] > w[23:16]) ? w[31:24] : w[23:16];
        lo = (w[15:8]  > w[7:0])   ? w[15:8]  : w[7:0];
        return (hi > lo) ? hi : lo;
    endfunction

    // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the winner.
    assign valid_dbl = {req_valid, req_valid};
    assign valid_rot = N_REQ'(valid_dbl >> rr_ptr);

    always_comb begin
        pick_off   = '0;
        pick_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                pick_off   = (ID_W+1)'(k);
                pick_found = 1'b1;
            end
        end
        pick_sum = {1'b0, rr_ptr} + pick_off;
        if (pick_sum >= (ID_W+1)'(N_REQ)) begin
            pick_sum = pick_sum - (ID_W+1)'(N_REQ);
        end
    end

    assign pick        = pick_sum[ID_W-1:0];
    assign grant_oh    = N_REQ'(1) << grant;
    assign grant_valid = |(req_valid & grant_oh);
    assign grant_last  = |(req_last & grant_oh);
    assign word        = 32'(req_data >> {grant, 5'b00000});
    assign word_max    = max4(word);
    assign hs          = (state == BURST) && grant_valid;
    assign end_burst   = hs && (grant_last || (cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = BURST;
            BURST:   if (end_burst)  state_next = RESULT;
            RESULT:  if (res_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            rr_ptr <= '0;
            acc    <= '0;
            cnt    <= '0;
            trunc  <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant <= pick;
                acc   <= '0;
                cnt   <= '0;
                trunc <= 1'b0;
            end
            if (hs) begin
                acc <= (word_max > acc) ? word_max : acc;
                // Terminating handshake leaves cnt alone so it never wraps.
                if (end_burst) begin
                    trunc <= !grant_last;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == RESULT && res_ready) begin
                rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign req_ready = (state == BURST) ? grant_oh : '0;
    assign res_valid = (state == RESULT);
    assign res_data  = res_valid ? acc : 8'h00;
    assign res_id    = res_valid ? grant : '0;
    assign res_trunc = res_valid ? trunc : 1'b0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_max_reduce_arbiter.sv
// Directed bench for max_reduce_arbiter: reset, single/multi-word bursts,
// round-robin order, truncation, result back-pressure and mid-burst reset.
module tb_max_reduce_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic [7:0]   res_data;
    logic [1:0]   res_id;
    logic         res_trunc;
    logic         res_ready;
    logic         busy;

    int total = 0;
    int bad   = 0;

    max_reduce_arbiter #(.N_REQ(4), .ID_W(2), .MAX_BURST(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_trunc (res_trunc),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one word and returns at the negedge after its handshake.
    task automatic drive_word(input int idx, input logic [31:0] w, input logic last);
        int waited;
        waited = 0;
        req_valid[idx] = 1'b1;
        req_data[32*idx +: 32] = w;
        req_last[idx] = last;
        while (req_ready[idx] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (req_ready[idx] !== 1'b1) begin
            bad++;
            $display("FAIL handshake_timeout req=%0d got ready=%b need bit set", idx, req_ready);
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        req_last[idx]  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL reset_hold got busy=%b res_valid=%b ready=%b need 0", busy, res_valid, req_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (res_data !== 8'h00 || res_id !== 2'd0 || res_trunc !== 1'b0) begin bad++; $display("FAIL reset_result got data=%h id=%0d trunc=%b need 0", res_data, res_id, res_trunc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b need 0", busy); end
    endtask

    task automatic test_single();
        req_valid[0] = 1'b1; req_data[31:0] = 32'h117F0380; req_last[0] = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got %b need 0", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b1 || req_ready !== 4'b0001 || res_valid !== 1'b0) begin bad++; $display("FAIL single_burst got busy=%b ready=%b res_valid=%b need 1/0001/0", busy, req_ready, res_valid); end
        @(negedge clk);
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_latency got res_valid=%b need 1", res_valid); end
        total++; if (res_data !== 8'h80 || res_id !== 2'd0 || res_trunc !== 1'b0) begin bad++; $display("FAIL single_result got data=%h id=%0d trunc=%b need 80/0/0", res_data, res_id, res_trunc); end
        total++; if (busy !== 1'b1 || req_ready !== 4'b0) begin bad++; $display("FAIL single_result_ctl got busy=%b ready=%b need 1/0000", busy, req_ready); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL single_done got busy=%b res_valid=%b need 0/0", busy, res_valid); end
    endtask

    task automatic test_multi_word(input int gap);
        drive_word(1, 32'h01020304, 1'b0);
        repeat (gap) @(negedge clk);
        drive_word(1, 32'hFF000000, 1'b0);
        repeat (gap) @(negedge clk);
        drive_word(1, 32'h00000010, 1'b1);
        total++; if (res_valid !== 1'b1 || res_data !== 8'hFF || res_id !== 2'd1 || res_trunc !== 1'b0) begin bad++; $display("FAIL multi_gap%0d got v=%b data=%h id=%0d trunc=%b need 1/ff/1/0", gap, res_valid, res_data, res_id, res_trunc); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] got_id[$];
        logic [7:0] got_data[$];
        logic [1:0] exp_id[5];
        logic [7:0] exp_data[5];
        int multi;
        int cycles;
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_data = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0A};
        multi = 0; cycles = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
        req_last = 4'b1111; req_valid = 4'b1111; res_ready = 1'b1;
        while (got_id.size() < 5 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if ($countones(req_ready) > 1) multi++;
            if (res_valid === 1'b1) begin
                got_id.push_back(res_id);
                got_data.push_back(res_data);
            end
        end
        req_valid = '0; req_last = '0;
        total++; if (got_id.size() != 5) begin bad++; $display("FAIL rr_count got %0d results need 5", got_id.size()); end
        for (int i = 0; i < 5 && i < got_id.size(); i++) begin
            total++; if (got_id[i] !== exp_id[i]) begin bad++; $display("FAIL rr_id[%0d] got %0d need %0d", i, got_id[i], exp_id[i]); end
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL rr_data[%0d] got %h need %h", i, got_data[i], exp_data[i]); end
        end
        total++; if (multi != 0) begin bad++; $display("FAIL rr_onehot got %0d multi-ready cycles need 0", multi); end
        @(negedge clk);
    endtask

    task automatic test_truncation();
        logic [31:0] w;
        int early;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            drive_word(2, w, (i == 19));
            if (i < 15 && res_valid !== 1'b0) early++;
            if (i == 15) begin
                total++; if (res_valid !== 1'b1 || res_data !== 8'h3F || res_id !== 2'd2 || res_trunc !== 1'b1) begin bad++; $display("FAIL trunc_first got v=%b data=%h id=%0d trunc=%b need 1/3f/2/1", res_valid, res_data, res_id, res_trunc); end
            end
        end
        total++; if (early != 0) begin bad++; $display("FAIL trunc_early got %0d early results need 0", early); end
        total++; if (res_valid !== 1'b1 || res_data !== 8'h4F || res_id !== 2'd2 || res_trunc !== 1'b0) begin bad++; $display("FAIL trunc_second got v=%b data=%h id=%0d trunc=%b need 1/4f/2/0", res_valid, res_data, res_id, res_trunc); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        drive_word(0, 32'h00000042, 1'b1);
        req_data[31:0] = 32'h00000099; req_data[63:32] = 32'h00000007;
        req_last = 4'b0011; req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            total++; if (res_valid !== 1'b1 || res_data !== 8'h42 || res_id !== 2'd0) begin bad++; $display("FAIL bp_hold[%0d] got v=%b data=%h id=%0d need 1/42/0", k, res_valid, res_data, res_id); end
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_ready[%0d] got %b need 0000", k, req_ready); end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_accept got v=%b busy=%b need 0/0", res_valid, busy); end
        @(negedge clk);
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant got %b need 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
        total++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'h07) begin bad++; $display("FAIL bp_next_result got v=%b id=%0d data=%h need 1/1/07", res_valid, res_id, res_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        drive_word(3, 32'h000000F0, 1'b0);
        drive_word(3, 32'h000000E0, 1'b0);
        total++; if (busy !== 1'b1 || req_ready !== 4'b1000) begin bad++; $display("FAIL rst_pre got busy=%b ready=%b need 1/1000", busy, req_ready); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || req_ready !== 4'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL rst_async got busy=%b ready=%b v=%b need 0", busy, req_ready, res_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        req_data[31:0] = 32'h00000005; req_data[127:96] = 32'h00000011;
        req_last = 4'b0001; req_valid = 4'b1001;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_prio got %b need 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
        total++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 8'h05) begin bad++; $display("FAIL rst_req0 got v=%b id=%0d data=%h need 1/0/05", res_valid, res_id, res_data); end
        drive_word(3, 32'h00000011, 1'b0);
        drive_word(3, 32'h00000022, 1'b0);
        drive_word(3, 32'h00000033, 1'b0);
        drive_word(3, 32'h00000044, 1'b1);
        total++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 8'h44 || res_trunc !== 1'b0) begin bad++; $display("FAIL rst_restart got v=%b id=%0d data=%h trunc=%b need 1/3/44/0", res_valid, res_id, res_data, res_trunc); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_word(0);
        test_multi_word(2);
        test_round_robin();
        test_truncation();
        test_backpressure();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
